// File: rtl/cipher_pkg.sv
// cipher_pkg: shared constants, mode codes and FSM state type for the decryption engine
package cipher_pkg;
    localparam int         P_PAR            = 227;
    localparam logic [7:0] NULL_CHAR        = 8'h00;
    localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
    localparam logic [7:0] LOWERCASE_Z_CHAR = 8'h7A;
    localparam logic [1:0] MODE_DEC         = 2'b01;
    localparam logic [1:0] MODE_ENC         = 2'b10;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/decrypt_mod_core.sv
// decrypt_mod_core: modular add of ciphertext and key plus lowercase range check
module decrypt_mod_core #(
    parameter int P_PAR = cipher_pkg::P_PAR
) (
    input  logic [7:0] ctxt,
    input  logic [7:0] key,
    output logic [7:0] ptxt,
    output logic       bad
);
    import cipher_pkg::*;
    localparam logic [9:0] MOD1 = 10'(P_PAR);
    localparam logic [9:0] MOD2 = 10'(2 * P_PAR);
    logic [9:0] sum;
    logic [9:0] red;
    // two-step conditional subtraction covers the largest possible 8-bit + 8-bit sum
    always_comb begin
        sum = {2'b00, ctxt} + {2'b00, key};
        red = sum >= MOD2 ? sum - MOD2 : sum >= MOD1 ? sum - MOD1 : sum;
    end
    assign ptxt = red[7:0];
    assign bad  = {2'b00, ctxt} >= MOD1 || red < {2'b00, LOWERCASE_A_CHAR} || red > {2'b00, LOWERCASE_Z_CHAR};
endmodule

// File: rtl/decryption_engine.sv
// decryption_engine: message-framed byte decryptor with registered outputs and good-character counter
module decryption_engine #(
    parameter int         P_PAR    = cipher_pkg::P_PAR,
    parameter logic [1:0] DEC_MODE = cipher_pkg::MODE_DEC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic [7:0] Public_key,
    input  logic       C_valid,
    input  logic [7:0] Ciphertext,
    input  logic       eom,
    output logic [7:0] Char_plaintext,
    output logic       P_ready,
    output logic       err_invalid_ctxt,
    output logic       busy,
    output logic [7:0] char_count
);
    import cipher_pkg::*;
    state_e     state_q;
    logic [7:0] key_q;
    logic [7:0] cnt_q;
    logic [7:0] char_q;
    logic       ready_q;
    logic       err_q;
    logic [7:0] ptxt;
    logic       bad;
    decrypt_mod_core #(.P_PAR(P_PAR)) u_core (
        .ctxt (Ciphertext),
        .key  (key_q),
        .ptxt (ptxt),
        .bad  (bad)
    );
    // message FSM; mode abort outranks eom and discards the byte of that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 8'h00;
            cnt_q   <= 8'h00;
            char_q  <= NULL_CHAR;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            char_q  <= NULL_CHAR;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (start && mode == DEC_MODE) begin
                    state_q <= RUN;
                    key_q   <= Public_key;
                    cnt_q   <= 8'h00;
                end
                RUN: if (mode != DEC_MODE) begin
                    state_q <= IDLE;
                end else if (C_valid) begin
                    if (bad) begin
                        err_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        char_q  <= ptxt;
                        cnt_q   <= cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
                    end
                    if (eom) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign Char_plaintext   = char_q;
    assign P_ready          = ready_q;
    assign err_invalid_ctxt = err_q;
    assign busy             = state_q == RUN;
    assign char_count       = cnt_q;
endmodule
